alu_issuer: RTL and testbench

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_issuer.sv | 214 +++++++++++++++++++++
 tb/tb_alu_issuer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issuer
//  Purpose  : Decodes one RV32I ALU-class instruction at a time, drives the
//             operands and op code to an external combinational ALU, then
//             captures and holds the result until downstream takes it.
//             Define ALU_ISSUER_BRANCH_EN to also issue BEQ/BNE as SUB.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issuer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instrValid,
    output logic        instrReady,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    output logic [3:0]  ALUControl,
    output logic [31:0] input1,
    output logic [31:0] input2,
    input  logic [31:0] ALUOut,
    input  logic        zero,
    output logic        resultValid,
    input  logic        resultReady,
    output logic [31:0] result,
    output logic        resultZero,
    output logic        illegal
);

    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
`ifdef ALU_ISSUER_BRANCH_EN
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
`endif

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;
    localparam logic [3:0] c_ALU_NONE = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_alu_ctrl;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic [31:0] r_result;
    logic        r_res_zero;
    logic        r_illegal;
    logic        r_inv_zero;

    logic        w_legal;
    logic [3:0]  w_ctrl;
    logic [31:0] w_in2;
    logic        w_inv_zero;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic        w_unused_bits;

    assign w_opcode      = instruction[6:0];
    assign w_funct3      = instruction[14:12];
    assign w_funct7      = instruction[31:25];
    assign w_imm_i       = {{20{instruction[31]}}, instruction[31:20]};
    assign w_imm_s       = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    // Register-number fields are resolved upstream; only operands arrive here.
    assign w_unused_bits = &{1'b0, instruction[19:15]};

    always_comb begin
        w_legal    = 1'b0;
        w_ctrl     = c_ALU_NONE;
        w_in2      = rs2Data;
        w_inv_zero = 1'b0;
        case (w_opcode)
            c_OP_REG: begin
                w_legal = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000:  w_ctrl = c_ALU_ADD;
                        3'b111:  w_ctrl = c_ALU_AND;
                        3'b110:  w_ctrl = c_ALU_OR;
                        3'b010:  w_ctrl = c_ALU_SLT;
                        default: w_legal = 1'b0;
                    endcase
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_ctrl = c_ALU_SUB;
                end else begin
                    w_legal = 1'b0;
                end
            end
            c_OP_IMM: begin
                w_legal = 1'b1;
                w_in2   = w_imm_i;
                case (w_funct3)
                    3'b000:  w_ctrl = c_ALU_ADD;
                    3'b111:  w_ctrl = c_ALU_AND;
                    3'b110:  w_ctrl = c_ALU_OR;
                    3'b010:  w_ctrl = c_ALU_SLT;
                    default: w_legal = 1'b0;
                endcase
            end
            c_OP_LOAD: begin
                w_legal = 1'b1;
                w_ctrl  = c_ALU_ADD;
                w_in2   = w_imm_i;
            end
            c_OP_STORE: begin
                w_legal = 1'b1;
                w_ctrl  = c_ALU_ADD;
                w_in2   = w_imm_s;
            end
`ifdef ALU_ISSUER_BRANCH_EN
            // Branches compare by subtraction; BNE reports the inverted flag.
            c_OP_BRANCH: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001) begin
                    w_legal    = 1'b1;
                    w_ctrl     = c_ALU_SUB;
                    w_inv_zero = w_funct3[0];
                end
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        instrReady   = 1'b0;
        resultValid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                instrReady = 1'b1;
                if (instrValid) begin
                    w_state_next = w_legal ? S_EXEC : S_RESP;
                end
            end
            S_EXEC: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                resultValid = 1'b1;
                if (resultReady) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_ctrl <= c_ALU_NONE;
            r_in1      <= 32'd0;
            r_in2      <= 32'd0;
            r_result   <= 32'd0;
            r_res_zero <= 1'b0;
            r_illegal  <= 1'b0;
            r_inv_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instrValid) begin
                        if (w_legal) begin
                            r_alu_ctrl <= w_ctrl;
                            r_in1      <= rs1Data;
                            r_in2      <= w_in2;
                            r_inv_zero <= w_inv_zero;
                        end else begin
                            r_alu_ctrl <= c_ALU_NONE;
                            r_result   <= 32'd0;
                            r_res_zero <= 1'b1;
                            r_illegal  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_result   <= ALUOut;
                    r_res_zero <= zero ^ r_inv_zero;
                    r_illegal  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ALUControl = r_alu_ctrl;
    assign input1     = r_in1;
    assign input2     = r_in2;
    assign result     = r_result;
    assign resultZero = r_res_zero;
    assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issuer
//  Purpose  : Self-checking bench for alu_issuer with a behavioural ALU and
//             an instruction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issuer;

    logic        clock;
    logic        reset_n;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instruction;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [3:0]  ALUControl;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [31:0] ALUOut;
    logic        zero;
    logic        resultValid;
    logic        resultReady;
    logic [31:0] result;
    logic        resultZero;
    logic        illegal;

    int          n_checks;
    int          n_errors;

    logic        e_ill;
    logic [3:0]  e_ctl;
    logic [31:0] e_in2;
    logic [31:0] e_res;
    logic        e_rz;

    alu_issuer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instrValid  (instrValid),
        .instrReady  (instrReady),
        .instruction (instruction),
        .rs1Data     (rs1Data),
        .rs2Data     (rs2Data),
        .ALUControl  (ALUControl),
        .input1      (input1),
        .input2      (input2),
        .ALUOut      (ALUOut),
        .zero        (zero),
        .resultValid (resultValid),
        .resultReady (resultReady),
        .result      (result),
        .resultZero  (resultZero),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural stand-in for the external ALU.
    always_comb begin
        case (ALUControl)
            4'b0010: ALUOut = input1 + input2;
            4'b0110: ALUOut = input1 - input2;
            4'b0000: ALUOut = input1 & input2;
            4'b0001: ALUOut = input1 | input2;
            4'b0111: ALUOut = ($signed(input1) < $signed(input2)) ? 32'd1 : 32'd0;
            default: ALUOut = 32'd0;
        endcase
        zero = (ALUOut == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction-level semantics: which operation, what second operand,
    // what the architectural answer is.
    function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b, output logic ill,
                                      output logic [3:0] ctl, output logic [31:0] in2,
                                      output logic [31:0] res, output logic rz);
        string       op;
        logic        bne;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        op    = "none";
        bne   = 1'b0;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        in2   = b;
        if (opc == 7'h33) begin
            if (f7 == 7'h00 && f3 == 3'd0) op = "add";
            if (f7 == 7'h20 && f3 == 3'd0) op = "sub";
            if (f7 == 7'h00 && f3 == 3'd7) op = "and";
            if (f7 == 7'h00 && f3 == 3'd6) op = "or";
            if (f7 == 7'h00 && f3 == 3'd2) op = "slt";
        end else if (opc == 7'h13) begin
            in2 = imm_i;
            if (f3 == 3'd0) op = "add";
            if (f3 == 3'd7) op = "and";
            if (f3 == 3'd6) op = "or";
            if (f3 == 3'd2) op = "slt";
        end else if (opc == 7'h03) begin
            in2 = imm_i;
            op  = "add";
        end else if (opc == 7'h23) begin
            in2 = imm_s;
            op  = "add";
        end
`ifdef ALU_ISSUER_BRANCH_EN
        else if (opc == 7'h63 && f3 < 3'd2) begin
            op  = "sub";
            bne = (f3 == 3'd1);
        end
`endif
        ill = (op == "none");
        ctl = 4'hF;
        res = 32'd0;
        if (op == "add") begin ctl = 4'b0010; res = a + in2; end
        if (op == "sub") begin ctl = 4'b0110; res = a - in2; end
        if (op == "and") begin ctl = 4'b0000; res = a & in2; end
        if (op == "or")  begin ctl = 4'b0001; res = a | in2; end
        if (op == "slt") begin ctl = 4'b0111; res = ($signed(a) < $signed(in2)) ? 32'd1 : 32'd0; end
        rz = ill ? 1'b1 : ((res == 32'd0) ^ bne);
    endfunction

    // Present one instruction, follow it to the response state, check latency and outputs.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        ref_model(ins, a, b, e_ill, e_ctl, e_in2, e_res, e_rz);
        @(negedge clock);
        instrValid  = 1'b1;
        instruction = ins;
        rs1Data     = a;
        rs2Data     = b;
        resultReady = 1'b0;
        check("instrReady_idle", 32'(instrReady), 32'd1);
        @(posedge clock);
        #1;
        instrValid  = 1'b0;
        instruction = $urandom;
        rs1Data     = $urandom;
        rs2Data     = $urandom;
        check("ALUControl", 32'(ALUControl), 32'(e_ctl));
        if (!e_ill) begin
            check("resultValid_exec", 32'(resultValid), 32'd0);
            check("input1", input1, a);
            check("input2", input2, e_in2);
            @(posedge clock);
            #1;
        end
        check("resultValid_resp", 32'(resultValid), 32'd1);
        check("result", result, e_res);
        check("resultZero", 32'(resultZero), 32'(e_rz));
        check("illegal", 32'(illegal), 32'(e_ill));
        check("instrReady_busy", 32'(instrReady), 32'd0);
    endtask

    task automatic release_result(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check("hold_valid", 32'(resultValid), 32'd1);
            check("hold_result", result, e_res);
            check("hold_zero", 32'(resultZero), 32'(e_rz));
            check("hold_illegal", 32'(illegal), 32'(e_ill));
            check("hold_ready", 32'(instrReady), 32'd0);
            check("hold_ctl", 32'(ALUControl), 32'(e_ctl));
        end
        @(negedge clock);
        resultReady = 1'b1;
        @(posedge clock);
        #1;
        resultReady = 1'b0;
        check("released_valid", 32'(resultValid), 32'd0);
        check("released_ready", 32'(instrReady), 32'd1);
        check("released_ctl", 32'(ALUControl), 32'(e_ctl));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(resultValid), 32'd0);
        check({tag, "_ctl"}, 32'(ALUControl), 32'hF);
        check({tag, "_in1"}, input1, 32'd0);
        check({tag, "_in2"}, input2, 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_rzero"}, 32'(resultZero), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    task automatic quiet_after_reset(input string tag);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check(tag, 32'(resultValid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        instrValid  = 1'b0;
        instruction = 32'd0;
        rs1Data     = 32'd0;
        rs2Data     = 32'd0;
        resultReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("reset");
        check("reset_ready", 32'(instrReady), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        issue(32'h00000033, 32'd5, 32'd7);
        check("add_ctl", 32'(ALUControl), 32'b0010);
        check("add_res", result, 32'd12);
        check("add_rz", 32'(resultZero), 32'd0);
        release_result(0);

        issue(32'h40000033, 32'h1234, 32'h1234);
        check("sub_ctl", 32'(ALUControl), 32'b0110);
        check("sub_res", result, 32'd0);
        check("sub_rz", 32'(resultZero), 32'd1);
        release_result(1);

        issue(32'hFFF00013, 32'd1, 32'd99);
        check("addi_in2", input2, 32'hFFFFFFFF);
        check("addi_res", result, 32'd0);
        check("addi_rz", 32'(resultZero), 32'd1);
        release_result(0);

        issue(32'h0000007F, 32'd3, 32'd4);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_res", result, 32'd0);
        release_result(3);

        issue(32'h00000063, 32'd9, 32'd9);
`ifdef ALU_ISSUER_BRANCH_EN
        check("beq_rz", 32'(resultZero), 32'd1);
        check("beq_ill", 32'(illegal), 32'd0);
`else
        check("beq_ill", 32'(illegal), 32'd1);
`endif
        release_result(0);

        // Asynchronous reset while a result is being held.
        issue(32'h00000033, 32'd20, 32'd22);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("rst_resp");
        quiet_after_reset("rst_resp_quiet");

        // Reset landing while the ALU cycle is in flight.
        @(negedge clock);
        instrValid  = 1'b1;
        instruction = 32'h00000033;
        rs1Data     = 32'd1;
        rs2Data     = 32'd2;
        @(posedge clock);
        #1;
        instrValid = 1'b0;
        reset_n    = 1'b0;
        #1;
        check_reset_state("rst_exec");
        quiet_after_reset("rst_exec_quiet");

        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: begin
                    ins[6:0] = 7'h33;
                    case ($urandom_range(0, 3))
                        0, 1:    ins[31:25] = 7'h00;
                        2:       ins[31:25] = 7'h20;
                        default: ;
                    endcase
                end
                3, 4:    ins[6:0] = 7'h13;
                5:       ins[6:0] = 7'h03;
                6:       ins[6:0] = 7'h23;
                7: begin
                    ins[6:0]   = 7'h63;
                    ins[14:12] = 3'($urandom_range(0, 3));
                end
                default: ;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            issue(ins, a, b);
            release_result($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
